account_store: RTL and testbench

- Parametrised successor to the ATM account memory: an N-entry account table with a command/response handshake and atomic, checked operations.
- Supported operations: PIN verify with failed-attempt lockout, debit with insufficient-funds check, credit with overflow check, account create/close, PIN change, unlock.
- Sits between the ATM controller FSM and storage; the controller issues one command at a time and waits for the response.
- Reset clears the table (no file preload); accounts are provisioned via CREATE.

---
 rtl/atm_pkg.sv | 46 ++++
 rtl/account_store_if.sv | 33 +++
 rtl/account_alu.sv | 96 +++++++++
 rtl/account_store.sv | 125 ++++++++++++
 tb/tb_account_store.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types for the account store: op and status codes, the account entry record and the
// command FSM state. Field widths are fixed here so every file sees the same entry layout.
package atm_pkg;

  localparam int unsigned PIN_W     = 16;
  localparam int unsigned BAL_W     = 16;  // unsigned Q14.2
  localparam int unsigned MAX_TRIES = 3;   // consecutive wrong PINs before lock, >= 1
  localparam int unsigned TRY_W     = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    OpRead   = 3'd0,
    OpVerify = 3'd1,
    OpDebit  = 3'd2,
    OpCredit = 3'd3,
    OpCreate = 3'd4,
    OpSetPin = 3'd5,
    OpUnlock = 3'd6,
    OpClose  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StatOk           = 3'd0,
    StatBadPin       = 3'd1,
    StatLocked       = 3'd2,
    StatInsufficient = 3'd3,
    StatOverflow     = 3'd4,
    StatInvalidAcct  = 3'd5,
    StatBadAddr      = 3'd6,
    StatReserved     = 3'd7
  } status_e;

  typedef struct packed {
    logic             valid;
    logic             locked;
    logic [TRY_W-1:0] tries;
    logic [PIN_W-1:0] pin;
    logic [BAL_W-1:0] balance;
  } account_entry_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/account_store_if.sv
// Command/response handshake between the ATM controller and the account store.
//   req_valid/req_ready : command handshake; op, addr, pin and amount qualify it
//   rsp_valid/rsp_ready : response handshake; status, balance and tries_left qualify it
// Modports: master = controller side, slave = account store side.
interface account_store_if
  import atm_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [PIN_W-1:0]  req_pin;
  logic [BAL_W-1:0]  req_amount;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_status;
  logic [BAL_W-1:0]  rsp_balance;
  logic [TRY_W-1:0]  rsp_tries_left;

  modport master (
    output req_valid, req_op, req_addr, req_pin, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_pin, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left
  );

endinterface

// File: rtl/account_alu.sv
// Combinational evaluation of one command against one account entry.
//   op, entry, pin, amount : the captured command and the addressed entry
//   new_entry              : entry contents after the command (equals entry when nothing changes)
//   write_en               : entry must be written back
//   status                 : result code
// Address range checking is done by the caller; this block assumes the address is in range.
module account_alu
  import atm_pkg::*;
(
  input  op_e              op,
  input  account_entry_t   entry,
  input  logic [PIN_W-1:0] pin,
  input  logic [BAL_W-1:0] amount,
  output account_entry_t   new_entry,
  output logic             write_en,
  output status_e          status
);

  logic [BAL_W:0]   sum;
  logic [TRY_W-1:0] tries_inc;

  always_comb begin
    new_entry = entry;
    write_en  = 1'b0;
    status    = StatOk;
    sum       = {1'b0, entry.balance} + {1'b0, amount};
    tries_inc = entry.tries + 1'b1;

    if (!entry.valid && (op != OpCreate)) begin
      status = StatInvalidAcct;
    end else if (entry.locked && (op inside {OpVerify, OpDebit, OpCredit, OpSetPin})) begin
      status = StatLocked;
    end else begin
      unique case (op)
        OpRead: status = StatOk;
        OpVerify: begin
          write_en = 1'b1;
          if (pin == entry.pin) begin
            new_entry.tries = '0;
          end else begin
            new_entry.tries = tries_inc;
            // The wrong PIN that exhausts the tries locks the account in the same write.
            if (tries_inc == TRY_W'(MAX_TRIES)) begin
              new_entry.locked = 1'b1;
              status           = StatLocked;
            end else begin
              status = StatBadPin;
            end
          end
        end
        OpDebit: begin
          if (amount > entry.balance) begin
            status = StatInsufficient;
          end else begin
            write_en          = 1'b1;
            new_entry.balance = entry.balance - amount;
          end
        end
        OpCredit: begin
          if (sum[BAL_W]) begin
            status = StatOverflow;
          end else begin
            write_en          = 1'b1;
            new_entry.balance = sum[BAL_W-1:0];
          end
        end
        OpCreate: begin
          write_en          = 1'b1;
          new_entry.valid   = 1'b1;
          new_entry.locked  = 1'b0;
          new_entry.tries   = '0;
          new_entry.pin     = pin;
          new_entry.balance = amount;
        end
        OpSetPin: begin
          write_en        = 1'b1;
          new_entry.pin   = pin;
          new_entry.tries = '0;
        end
        OpUnlock: begin
          write_en         = 1'b1;
          new_entry.locked = 1'b0;
          new_entry.tries  = '0;
        end
        OpClose: begin
          write_en          = 1'b1;
          new_entry.valid   = 1'b0;
          new_entry.locked  = 1'b0;
          new_entry.tries   = '0;
          new_entry.balance = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/account_store.sv
// N-entry account table behind a command/response handshake. One command at a time:
// IDLE captures the command, EXEC evaluates it and performs at most one table write,
// RESP presents the registered response until it is consumed.
//   clk : clock, rising edge
//   RST : asynchronous active-low reset; clears the table and drops any in-flight command
//   bus : account_store_if slave (command and response handshakes)
module account_store
  import atm_pkg::*;
#(
  parameter int unsigned NUM_ACCOUNTS = 16,
  parameter int unsigned ADDR_W       = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input logic              clk,
  input logic              RST,
  account_store_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIN_W-1:0]  pin_q;
  logic [BAL_W-1:0]  amount_q;

  account_entry_t    table_q [NUM_ACCOUNTS];

  logic              bad_addr;
  logic [IDX_W-1:0]  idx;
  account_entry_t    cur_entry;
  account_entry_t    new_entry;
  logic              write_en;
  status_e           alu_status;

  status_e           rsp_status_q;
  logic [BAL_W-1:0]  rsp_balance_q;
  logic [TRY_W-1:0]  rsp_tries_q;

  logic              accept;

  // Widened compare so the range check also works when ADDR_W exceeds the index width.
  assign bad_addr  = 32'(addr_q) >= NUM_ACCOUNTS;
  assign idx       = addr_q[IDX_W-1:0];
  assign cur_entry = table_q[idx];
  assign accept    = (state_q == StIdle) && bus.req_valid;

  account_alu u_alu (
    .op        (op_q),
    .entry     (cur_entry),
    .pin       (pin_q),
    .amount    (amount_q),
    .new_entry (new_entry),
    .write_en  (write_en),
    .status    (alu_status)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      op_q     <= OpRead;
      addr_q   <= '0;
      pin_q    <= '0;
      amount_q <= '0;
    end else if (accept) begin
      op_q     <= op_e'(bus.req_op);
      addr_q   <= bus.req_addr;
      pin_q    <= bus.req_pin;
      amount_q <= bus.req_amount;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
        table_q[i] <= '0;
      end
    end else if ((state_q == StExec) && !bad_addr && write_en) begin
      table_q[idx] <= new_entry;
    end
  end

  // new_entry mirrors the stored entry when nothing is written, so it always gives the
  // post-operation view for the response.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rsp_status_q  <= StatOk;
      rsp_balance_q <= '0;
      rsp_tries_q   <= '0;
    end else if (state_q == StExec) begin
      if (bad_addr) begin
        rsp_status_q  <= StatBadAddr;
        rsp_balance_q <= '0;
        rsp_tries_q   <= '0;
      end else begin
        rsp_status_q  <= alu_status;
        rsp_balance_q <= new_entry.balance;
        rsp_tries_q   <= TRY_W'(MAX_TRIES) - new_entry.tries;
      end
    end
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.rsp_valid      = (state_q == StResp);
  assign bus.rsp_status     = rsp_status_q;
  assign bus.rsp_balance    = rsp_balance_q;
  assign bus.rsp_tries_left = rsp_tries_q;

endmodule

// File: tb/tb_account_store.sv
// Bench for account_store: directed sequence followed by random commands, every response
// compared against a behavioural model of the account table.
module tb_account_store;
  import atm_pkg::*;

  localparam int NUM    = 16;
  localparam int ADDR_W = 5;  // one extra bit so out-of-range addresses can be issued

  logic clk = 1'b0;
  logic RST = 1'b0;

  account_store_if #(.ADDR_W(ADDR_W)) bus ();

  account_store #(
    .NUM_ACCOUNTS (NUM),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference account table
  bit m_valid  [NUM];
  bit m_locked [NUM];
  int m_tries  [NUM];
  int m_pin    [NUM];
  int m_bal    [NUM];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_valid[i] = 0; m_locked[i] = 0; m_tries[i] = 0; m_pin[i] = 0; m_bal[i] = 0;
    end
  endtask

  task automatic model_exec(input int op, input int a, input int pin, input int amt,
                            output int st, output int bal, output int tl);
    if (a >= NUM) begin
      st = 6; bal = 0; tl = 0;
      return;
    end
    if (!m_valid[a] && op != 4) st = 5;
    else if (m_locked[a] && (op == 1 || op == 2 || op == 3 || op == 5)) st = 2;
    else begin
      st = 0;
      case (op)
        1: if (pin == m_pin[a]) m_tries[a] = 0;
           else begin
             m_tries[a] = m_tries[a] + 1;
             if (m_tries[a] == int'(MAX_TRIES)) begin m_locked[a] = 1; st = 2; end
             else st = 1;
           end
        2: if (amt > m_bal[a]) st = 3; else m_bal[a] = m_bal[a] - amt;
        3: if (m_bal[a] + amt > 65535) st = 4; else m_bal[a] = m_bal[a] + amt;
        4: begin
             m_valid[a] = 1; m_locked[a] = 0; m_tries[a] = 0; m_pin[a] = pin; m_bal[a] = amt;
           end
        5: begin m_pin[a] = pin; m_tries[a] = 0; end
        6: begin m_locked[a] = 0; m_tries[a] = 0; end
        7: begin m_valid[a] = 0; m_locked[a] = 0; m_tries[a] = 0; m_bal[a] = 0; end
        default: ;
      endcase
    end
    bal = m_bal[a];
    tl  = int'(MAX_TRIES) - m_tries[a];
  endtask

  // Issue one command; response is expected two cycles after it is presented. With stall > 0
  // rsp_ready stays low that many extra cycles while a competing command is pushed in.
  task automatic do_cmd(input int op, input int a, input int pin, input int amt,
                        input int stall, output int got_st, output int got_bal);
    int e_st, e_bal, e_tl;
    logic [2:0] held_st;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'(op);
    bus.req_addr   = ADDR_W'(a);
    bus.req_pin    = 16'(pin);
    bus.req_amount = 16'(amt);
    bus.rsp_ready  = (stall == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom_range(0, 7));
    check_eq("lat_exec_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("exec_req_ready", 32'(bus.req_ready), 0);
    model_exec(op, a, pin, amt, e_st, e_bal, e_tl);
    @(negedge clk);
    check_eq("lat_rsp_valid", 32'(bus.rsp_valid), 1);
    check_eq($sformatf("status op%0d a%0d", op, a), 32'(bus.rsp_status), 32'(e_st));
    check_eq($sformatf("balance op%0d a%0d", op, a), 32'(bus.rsp_balance), 32'(e_bal));
    if (e_st != 6)
      check_eq($sformatf("tries_left op%0d a%0d", op, a), 32'(bus.rsp_tries_left), 32'(e_tl));
    got_st  = int'(bus.rsp_status);
    got_bal = int'(bus.rsp_balance);
    held_st = bus.rsp_status;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid  = 1'b1;
      bus.req_op     = 3'(OpCreate);
      bus.req_amount = 16'h0BAD;
      @(negedge clk);
      check_eq("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      check_eq("stall_status", 32'(bus.rsp_status), 32'(held_st));
      check_eq("stall_req_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int st, bal;
    int op, a, pin, amt;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_pin    = '0;
    bus.req_amount = '0;
    bus.rsp_ready  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check_eq("reset_req_ready", 32'(bus.req_ready), 1);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("reset_rsp_status", 32'(bus.rsp_status), 0);
    check_eq("reset_rsp_balance", 32'(bus.rsp_balance), 0);
    check_eq("reset_rsp_tries", 32'(bus.rsp_tries_left), 0);

    do_cmd(0, 0, 0, 0, 0, st, bal);
    check_eq("read_empty", 32'(st), 5);
    do_cmd(0, 16, 0, 0, 0, st, bal);
    check_eq("read_bad_addr", 32'(st), 6);
    do_cmd(4, 3, 'h1234, 'h0190, 0, st, bal);
    do_cmd(1, 3, 'h1234, 0, 0, st, bal);
    check_eq("verify_ok", 32'(st), 0);
    do_cmd(1, 3, 'h1111, 0, 0, st, bal);
    do_cmd(1, 3, 'h1111, 0, 0, st, bal);
    do_cmd(1, 3, 'h1111, 0, 0, st, bal);
    check_eq("third_bad_pin_locks", 32'(st), 2);
    do_cmd(2, 3, 0, 1, 0, st, bal);
    check_eq("debit_locked", 32'(st), 2);
    do_cmd(6, 3, 0, 0, 0, st, bal);
    do_cmd(1, 3, 'h1234, 0, 0, st, bal);
    do_cmd(2, 3, 0, 'h0191, 0, st, bal);
    check_eq("debit_insufficient_bal", 32'(bal), 'h0190);
    do_cmd(2, 3, 0, 'h0190, 0, st, bal);
    check_eq("debit_exact_bal", 32'(bal), 0);
    do_cmd(3, 3, 0, 'hFFFF, 0, st, bal);
    do_cmd(3, 3, 0, 'h0001, 0, st, bal);
    check_eq("credit_overflow", 32'(st), 4);
    do_cmd(3, 3, 0, 'h0000, 0, st, bal);
    check_eq("credit_zero_bal", 32'(bal), 'hFFFF);

    // Backpressure with an ignored competing command, then confirm the table is untouched
    do_cmd(0, 3, 0, 0, 5, st, bal);
    do_cmd(0, 3, 0, 0, 0, st, bal);
    check_eq("after_stall_bal", 32'(bal), 'hFFFF);

    // Reset while a DEBIT is in EXEC
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'(OpDebit);
    bus.req_addr   = ADDR_W'(3);
    bus.req_amount = 16'h0001;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    RST = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("midop_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("midop_req_ready", 32'(bus.req_ready), 1);
    check_eq("midop_status", 32'(bus.rsp_status), 0);
    RST = 1'b1;
    do_cmd(0, 3, 0, 0, 0, st, bal);
    check_eq("after_reset_read", 32'(st), 5);

    // Random commands concentrated on a few accounts so state builds up
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 2) != 0) op = 4;
      a   = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 3);
      pin = $urandom_range(0, 1) ? 'h1234 : 'h1111;
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 512);
      do_cmd(op, a, pin, amt, ($urandom_range(0, 7) == 0) ? 2 : 0, st, bal);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
